// File: rtl/aes_round_key_buffer_if.sv
// rtl/aes_round_key_buffer_if.sv - round-key load/read bundle; KEYBUF_DEC_ORDER_EN adds dec_mode
interface aes_round_key_buffer_if #(
    parameter int KEY_W = 128,
    parameter int IDX_W = 4
);
    logic             start;
    logic             rk_valid;
    logic [KEY_W-1:0] rk_data;
    logic             rk_ready;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             keys_ready;
    logic             err;
`ifdef KEYBUF_DEC_ORDER_EN
    logic             dec_mode;
`endif

    modport master (
        output start, rk_valid, rk_data, rd_en, rd_idx,
`ifdef KEYBUF_DEC_ORDER_EN
        output dec_mode,
`endif
        input  rk_ready, rd_key, rd_valid, keys_ready, err
    );

    modport slave (
        input  start, rk_valid, rk_data, rd_en, rd_idx,
`ifdef KEYBUF_DEC_ORDER_EN
        input  dec_mode,
`endif
        output rk_ready, rd_key, rd_valid, keys_ready, err
    );
endinterface

// File: rtl/aes_round_key_buffer.sv
// rtl/aes_round_key_buffer.sv - AES-128 round-key store with indexed read; KEYBUF_DEC_ORDER_EN enables reversed reads
module aes_round_key_buffer #(
    parameter int NUM_KEYS = 11,
    parameter int KEY_W    = 128,
    parameter int IDX_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_round_key_buffer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [KEY_W-1:0] mem_q [NUM_KEYS];
    logic [KEY_W-1:0] rd_key_q, rd_key_d;
    logic             rd_valid_q, rd_valid_d;
    logic             keys_ready_q, keys_ready_d;
    logic             err_q, err_d;

    logic             beat;
    logic             rd_ok;
    logic             dec;
    logic [IDX_W-1:0] rd_addr;

`ifdef KEYBUF_DEC_ORDER_EN
    assign dec = bus.dec_mode;
`else
    assign dec = 1'b0;
`endif

    // start wins over a same-cycle beat, so that beat is dropped
    assign beat    = bus.rk_valid && (state_q == LOAD) && !bus.start;
    assign rd_ok   = bus.rd_en && (state_q == READY) && (bus.rd_idx <= LAST);
    assign rd_addr = dec ? (LAST - bus.rd_idx) : bus.rd_idx;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        keys_ready_d = keys_ready_q;
        if (bus.start) begin
            state_d      = LOAD;
            wr_ptr_d     = '0;
            keys_ready_d = 1'b0;
        end else if (beat) begin
            if (wr_ptr_q == LAST) begin
                state_d      = READY;
                wr_ptr_d     = '0;
                keys_ready_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
        end
    end

    // reads look at pre-start state, so a read coincident with start still completes
    always_comb begin
        rd_valid_d = rd_ok;
        err_d      = bus.rd_en && !rd_ok;
        rd_key_d   = rd_ok ? mem_q[rd_addr] : rd_key_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_key_q     <= '0;
            rd_valid_q   <= 1'b0;
            keys_ready_q <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_key_q     <= rd_key_d;
            rd_valid_q   <= rd_valid_d;
            keys_ready_q <= keys_ready_d;
            err_q        <= err_d;
            if (beat) begin
                mem_q[wr_ptr_q] <= bus.rk_data;
            end
        end
    end

    assign bus.rk_ready   = (state_q == LOAD);
    assign bus.rd_key     = rd_key_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_aes_round_key_buffer.sv
// tb/tb_aes_round_key_buffer.sv - scoreboard bench for aes_round_key_buffer
module tb_aes_round_key_buffer;
    localparam int NK = 11;

    typedef struct {
        logic         is_err;
        logic [127:0] key;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [127:0] rk      [NK];
    logic [127:0] exp_mem [NK];
    logic [127:0] last_key = '0;
    bit           model_ready = 1'b0;

    aes_round_key_buffer_if #(.KEY_W(128), .IDX_W(4)) bus ();

    aes_round_key_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1 || bus.err === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rd: rd_valid=%b err=%b with no read pending", bus.rd_valid, bus.err);
            end else begin
                mon_e = sb.pop_front();
                if (bus.err !== mon_e.is_err || bus.rd_valid !== !mon_e.is_err ||
                    bus.rd_key !== mon_e.key || cyc != mon_e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL rd_resp: got valid=%b err=%b key=%h cyc=%0d, expected err=%b key=%h cyc=%0d",
                             bus.rd_valid, bus.err, bus.rd_key, cyc, mon_e.is_err, mon_e.key, mon_e.cyc + 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input int idx, input bit dec);
        exp_t e;
        bit   legal;
        legal = model_ready && (idx < NK);
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'(idx);
`ifdef KEYBUF_DEC_ORDER_EN
        bus.dec_mode = dec;
`endif
        if (legal) last_key = exp_mem[dec ? (NK - 1 - idx) : idx];
        e.is_err = !legal;
        e.key    = last_key;
        e.cyc    = cyc;
        sb.push_back(e);
    endtask

    task automatic rd(input int idx, input bit dec);
        push_rd(idx, dec);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic start_load();
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        model_ready = 1'b0;
    endtask

    task automatic load(input bit toggle, input int nbeats, input int rd_at, input logic [127:0] pat);
        int beat = 0;
        for (int t = 0; t < 100 && beat < nbeats; t++) begin
            bus.rk_valid = toggle ? (t % 2 == 0) : 1'b1;
            bus.rk_data  = rk[beat] ^ pat;
            if (bus.rk_valid && beat == rd_at) push_rd(rd_at, 1'b0);
            #1;
            chk("rk_ready_load", bus.rk_ready, 1);
            chk("keys_ready_load", bus.keys_ready, 0);
            if (bus.rk_valid) begin
                exp_mem[beat] = bus.rk_data;
                beat++;
            end
            tick();
            bus.rd_en = 1'b0;
        end
        bus.rk_valid = 1'b0;
        if (beat != nbeats) begin
            n_vec++;
            n_fail++;
            $display("FAIL load_timeout: got %0d beats expected %0d", beat, nbeats);
        end
        if (nbeats == NK) model_ready = 1'b1;
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        bus.start    = 1'b0;
        bus.rk_valid = 1'b0;
        bus.rk_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_idx   = '0;
`ifdef KEYBUF_DEC_ORDER_EN
        bus.dec_mode = 1'b0;
`endif

        #1 reset = 1'b0;
        #2;
        chk("rst_rk_ready", bus.rk_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_keys_ready", bus.keys_ready, 0);
        chk("rst_rd_key", bus.rd_key, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        start_load();
        load(1'b0, NK, -1, '0);
        chk("keys_ready_after_load", bus.keys_ready, 1);
        chk("rk_ready_after_load", bus.rk_ready, 0);

        bus.rk_valid = 1'b1;
        bus.rk_data  = {128{1'b1}};
        tick();
        bus.rk_valid = 1'b0;

        rd(0, 1'b0);
        rd(1, 1'b0);
        rd(10, 1'b0);
        rd(11, 1'b0);
        rd(15, 1'b0);

        start_load();
        load(1'b1, NK, -1, 128'h5a5a_0f0f_3c3c_a5a5_ffff_0000_1234_8765);
        chk("keys_ready_after_toggle", bus.keys_ready, 1);
        for (int i = 0; i < NK; i++) rd(i, 1'b0);

        start_load();
        load(1'b0, 5, -1, '0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_rk_ready", bus.rk_ready, 0);
        chk("midrst_rd_key", bus.rd_key, 0);
        chk("midrst_keys_ready", bus.keys_ready, 0);
        chk("midrst_rd_valid", bus.rd_valid, 0);
        chk("midrst_err", bus.err, 0);
        last_key    = '0;
        model_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        rd(0, 1'b0);
        start_load();
        load(1'b0, NK, 4, '0);
        rd(3, 1'b0);
        rd(7, 1'b0);

        bus.start = 1'b1;
        push_rd(3, 1'b0);
        tick();
        bus.start   = 1'b0;
        bus.rd_en   = 1'b0;
        model_ready = 1'b0;
        chk("keys_ready_after_start", bus.keys_ready, 0);
        chk("rk_ready_after_start", bus.rk_ready, 1);
        rd(5, 1'b0);

`ifdef KEYBUF_DEC_ORDER_EN
        load(1'b0, NK, -1, '0);
        rd(0, 1'b1);
        rd(10, 1'b1);
        rd(4, 1'b1);
        rd(4, 1'b0);
`endif

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_drain: got %0d responses outstanding expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
